cpu_checker: RTL and testbench
==============================

Name: cpu_checker

Overview:
- Serial character-stream recogniser for CPU trace lines.
- Takes one ASCII character per clock and reports whether the line just terminated by '#' was a well-formed register-write record or memory-write record.
- Sits beside the trace/UART path as a self-check monitor.

Parameters:
- None. Field widths are fixed constants: time 1–4 digits, PC 8 hex, GRF 1–4 digits, address 8 hex, data 8 hex.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- char  input  8  ASCII character, sampled every rising edge.
- format_type  output  2  2'b01 = valid register record, 2'b10 = valid memory record, 2'b00 = otherwise.

Behaviour:
- Grammar for a register record (terminal symbols are quoted):
  - '^' T '@' P ':' S* '$' G S* '<=' S* D '#'
- Grammar for a memory record:
  - '^' T '@' P ':' S* '*' A S* '<=' S* D '#'
- Field definitions:
  - T = 1–4 decimal digits.
  - G = 1–4 decimal digits.
  - P, A and D = exactly 8 hex digits.
  - Hex digits are 0-9 and a-f only; uppercase A-F is invalid.
  - S* = zero or more spaces (0x20).
  - No spaces are allowed anywhere else, including between D and '#'.
- One character is consumed per clk edge. No handshake; every cycle's char is meaningful.
- State machine (Moore) states: IDLE, TIME, PC, COLON_SP, GRF, ADDR, SP_LT, EQ, SP_DATA, DATA, HASH_WAIT, DONE_REG, DONE_MEM.
  - A 3-bit digit counter tracks field length.
- Transitions:
  - '^' from any state → TIME with the count cleared. This is a restart and takes priority over every other rule.
  - TIME: a decimal digit increments the count, but a 5th digit → IDLE. '@' with count 1–4 → PC.
  - PC: exactly 8 hex digits, then ':' → COLON_SP.
  - COLON_SP: a space stays. '$' → GRF. '*' → ADDR.
  - GRF: 1–4 decimal digits. Then a space → SP_LT, or '<' → EQ.
  - ADDR: exactly 8 hex digits. Then a space → SP_LT, or '<' → EQ.
  - SP_LT: a space stays. '<' → EQ.
  - EQ: '=' → SP_DATA.
  - SP_DATA: a space stays. A hex digit → DATA with count 1.
  - DATA: more hex digits up to count 8. After 8 digits, '#' → DONE_REG or DONE_MEM, selected by a record-kind flag latched at '$'/'*'.
  - Any character not allowed by the rules above → IDLE.
  - A 9th data digit → IDLE.
  - '#' before 8 data digits → IDLE.
- format_type output:
  - Purely decoded from state: 01 in DONE_REG, 10 in DONE_MEM, else 00.
  - It is valid in the cycle immediately after the edge that sampled '#', and lasts exactly until the next edge.
- In DONE states, '^' begins a new record; any other character → IDLE.
- Reset (asynchronous, active-low): state = IDLE, counters and kind flag cleared, format_type = 00.
- Reset asserted mid-record aborts the record. After release, a fresh '^' is required.

Decomposition:
- Shared package holds:
  - the state enum;
  - the ASCII constants for '^', '@', ':', '$', '*', '<', '=', '#' and space;
  - digit-limit constants (TIME_MAX=4, GRF_MAX=4, HEX_LEN=8).
- One natural sub-module, cpu_checker_chclass: a combinational classifier for char that outputs is_dec, is_hex and the per-symbol strobes.

Test Plan:
- "^242@000030f4: $31 <=12345678#" → format_type=01 for one cycle after '#', then 00.
- "^338@00003130: *00000088 <= ffffb528#" → 10. The same record with "Ffffb528" or "ffffB528" → 00.
- Data length errors give 00:
  - "<=123215#" (6 digits);
  - "<=1232158998#" (10 digits);
  - "<=#" (empty);
  - "ffffb52812#";
  - "ffffb52B#".
- Space before '#' (e.g. "<=   ab123215 #") → 00. Multiple spaces after ':' and around "<=" with valid 8 lowercase hex digits → 01/10 as appropriate.
- Field limits:
  - "^12345@…" → 00;
  - "$12345" → 00;
  - 7-digit PC → 00;
  - time/GRF of 1 and 4 digits → accepted.
- Back-to-back records with no gap give a correct result per record. '^' mid-record restarts cleanly. reset low mid-record → 00 immediately (asynchronously), and the remainder of that record → 00.

Source files
------------

// File: rtl/cpu_checker_pkg.sv
// cpu_checker_pkg: recogniser states, ASCII symbols and field-length limits
// shared by the trace-line checker and its character classifier.
package cpu_checker_pkg;

    typedef enum logic [3:0] {
        IDLE, TIME, PC, COLON_SP, GRF, ADDR, SP_LT, EQ,
        SP_DATA, DATA, HASH_WAIT, DONE_REG, DONE_MEM
    } state_t;

    localparam logic [7:0] CH_CARET  = 8'h5e;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3a;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2a;
    localparam logic [7:0] CH_LT     = 8'h3c;
    localparam logic [7:0] CH_EQ     = 8'h3d;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    // one extra bit over 3 so a full 8-digit field is distinguishable from zero
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] TIME_MAX = 4'd4;
    localparam logic [CNT_W-1:0] GRF_MAX  = 4'd4;
    localparam logic [CNT_W-1:0] HEX_LEN  = 4'd8;

endpackage

// File: rtl/cpu_checker_chclass.sv
// cpu_checker_chclass: combinational classifier turning one ASCII character
// into digit-class flags and per-symbol strobes.
module cpu_checker_chclass
    import cpu_checker_pkg::*;
(
    input  logic [7:0] char,
    output logic       is_dec,
    output logic       is_hex,
    output logic       is_caret,
    output logic       is_at,
    output logic       is_colon,
    output logic       is_dollar,
    output logic       is_star,
    output logic       is_lt,
    output logic       is_eq,
    output logic       is_hash,
    output logic       is_space
);

    // lowercase a-f only; uppercase hex is rejected by design
    assign is_dec    = char >= 8'h30 && char <= 8'h39;
    assign is_hex    = is_dec || (char >= 8'h61 && char <= 8'h66);
    assign is_caret  = char == CH_CARET;
    assign is_at     = char == CH_AT;
    assign is_colon  = char == CH_COLON;
    assign is_dollar = char == CH_DOLLAR;
    assign is_star   = char == CH_STAR;
    assign is_lt     = char == CH_LT;
    assign is_eq     = char == CH_EQ;
    assign is_hash   = char == CH_HASH;
    assign is_space  = char == CH_SPACE;

endmodule

// File: rtl/cpu_checker.sv
// cpu_checker: one-character-per-clock recogniser for CPU trace lines; flags
// well-formed register (01) or memory (10) write records after their '#'.
module cpu_checker
    import cpu_checker_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] char,
    output logic [1:0] format_type
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             is_mem, is_mem_nxt;
    logic is_dec, is_hex, is_caret, is_at, is_colon, is_dollar;
    logic is_star, is_lt, is_eq, is_hash, is_space;

    cpu_checker_chclass u_chclass (
        .char      (char),
        .is_dec    (is_dec),
        .is_hex    (is_hex),
        .is_caret  (is_caret),
        .is_at     (is_at),
        .is_colon  (is_colon),
        .is_dollar (is_dollar),
        .is_star   (is_star),
        .is_lt     (is_lt),
        .is_eq     (is_eq),
        .is_hash   (is_hash),
        .is_space  (is_space)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            is_mem <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            is_mem <= is_mem_nxt;
        end
    end

    // count advances by default; only field-entry transitions reload it
    always_comb begin
        state_nxt  = IDLE;
        cnt_nxt    = cnt + 1'b1;
        is_mem_nxt = is_mem;
        if (is_caret) begin
            state_nxt = TIME;
            cnt_nxt   = '0;
        end else begin
            case (state)
                TIME:
                    if (is_dec && cnt < TIME_MAX) state_nxt = TIME;
                    else if (is_at && cnt != '0) begin
                        state_nxt = PC;
                        cnt_nxt   = '0;
                    end
                PC:
                    if (is_hex && cnt < HEX_LEN) state_nxt = PC;
                    else if (is_colon && cnt == HEX_LEN) state_nxt = COLON_SP;
                COLON_SP:
                    if (is_space) state_nxt = COLON_SP;
                    else if (is_dollar || is_star) begin
                        state_nxt  = is_star ? ADDR : GRF;
                        cnt_nxt    = '0;
                        is_mem_nxt = is_star;
                    end
                GRF:
                    if (is_dec && cnt < GRF_MAX) state_nxt = GRF;
                    else if (cnt != '0) state_nxt = is_space ? SP_LT : (is_lt ? EQ : IDLE);
                ADDR:
                    if (is_hex && cnt < HEX_LEN) state_nxt = ADDR;
                    else if (cnt == HEX_LEN) state_nxt = is_space ? SP_LT : (is_lt ? EQ : IDLE);
                SP_LT:
                    state_nxt = is_space ? SP_LT : (is_lt ? EQ : IDLE);
                EQ:
                    state_nxt = is_eq ? SP_DATA : IDLE;
                SP_DATA:
                    if (is_space) state_nxt = SP_DATA;
                    else if (is_hex) begin
                        state_nxt = DATA;
                        cnt_nxt   = CNT_W'(1);
                    end
                DATA:
                    if (is_hex) state_nxt = (cnt == HEX_LEN - 1'b1) ? HASH_WAIT : DATA;
                HASH_WAIT:
                    if (is_hash) state_nxt = is_mem ? DONE_MEM : DONE_REG;
                default:
                    state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        format_type = (state == DONE_REG) ? 2'b01 : (state == DONE_MEM) ? 2'b10 : 2'b00;
    end

endmodule

// File: tb/tb_cpu_checker.sv
// tb_cpu_checker: directed records from the test plan plus randomized records
// scored against a recursive-descent parser of the record grammar.
module tb_cpu_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] char = 8'h00;
    logic [1:0] format_type;

    int         checks = 0;
    int         errors = 0;
    byte        line[$];
    bit         active = 1'b0;
    logic [1:0] exp_ft = 2'b00;

    cpu_checker dut (
        .clk         (clk),
        .reset       (reset),
        .char        (char),
        .format_type (format_type)
    );

    always #5 clk = ~clk;

    function automatic bit dec(byte c);
        return c >= "0" && c <= "9";
    endfunction

    function automatic bit hex(byte c);
        return dec(c) || (c >= "a" && c <= "f");
    endfunction

    function automatic int run_len(int i, bit want_hex);
        int n = 0;
        while (i + n < line.size() && (want_hex ? hex(line[i+n]) : dec(line[i+n]))) n++;
        return n;
    endfunction

    function automatic int skip_sp(int i);
        while (i < line.size() && line[i] == " ") i++;
        return i;
    endfunction

    function automatic bit at(int i, byte c);
        return i < line.size() && line[i] == c;
    endfunction

    // parses the text since the last '^' against the record grammar
    function automatic logic [1:0] ref_parse();
        int i;
        int n;
        logic [1:0] kind;
        i = 1;
        n = run_len(i, 1'b0);
        if (n < 1 || n > 4 || !at(i + n, "@")) return 2'b00;
        i = i + n + 1;
        n = run_len(i, 1'b1);
        if (n != 8 || !at(i + n, ":")) return 2'b00;
        i = skip_sp(i + n + 1);
        if (at(i, "$")) begin
            kind = 2'b01;
            n = run_len(i + 1, 1'b0);
            if (n < 1 || n > 4) return 2'b00;
        end else if (at(i, "*")) begin
            kind = 2'b10;
            n = run_len(i + 1, 1'b1);
            if (n != 8) return 2'b00;
        end else return 2'b00;
        i = skip_sp(i + 1 + n);
        if (!at(i, "<") || !at(i + 1, "=")) return 2'b00;
        i = skip_sp(i + 2);
        n = run_len(i, 1'b1);
        if (n != 8 || !at(i + n, "#") || i + n + 1 != line.size()) return 2'b00;
        return kind;
    endfunction

    task automatic send_char(input byte c);
        @(negedge clk);
        char = c;
        @(posedge clk);
        #1;
        if (c == "^") begin
            line.delete();
            active = 1'b1;
        end
        if (active) line.push_back(c);
        exp_ft = (active && c == "#") ? ref_parse() : 2'b00;
    endtask

    function automatic string digs(int n, bit hx);
        string pool = "0123456789abcdef";
        string s = "";
        byte c;
        for (int k = 0; k < n; k++) begin
            c = pool[hx ? $urandom_range(0, 15) : $urandom_range(0, 9)];
            if (hx && $urandom_range(0, 39) == 0) c = byte'($urandom_range(65, 70));
            s = {s, $sformatf("%c", c)};
        end
        return s;
    endfunction

    function automatic int pick(int lo, int hi);
        int r = int'($urandom_range(0, 9));
        if (r == 0) return lo - 1;
        if (r == 1) return hi + 1;
        return int'($urandom_range(lo, hi));
    endfunction

    function automatic string sp();
        int n = int'($urandom_range(0, 2));
        return n == 0 ? "" : (n == 1 ? " " : "  ");
    endfunction

    function automatic string rand_record();
        string s;
        string junk = "^@:$*<=# 0aF";
        s = {"^", digs(pick(1, 4), 1'b0), "@", digs(pick(8, 8), 1'b1), ":", sp()};
        if ($urandom_range(0, 1) == 1) s = {s, "*", digs(pick(8, 8), 1'b1)};
        else s = {s, "$", digs(pick(1, 4), 1'b0)};
        s = {s, sp(), "<=", sp(), digs(pick(8, 8), 1'b1)};
        if ($urandom_range(0, 19) == 0) s = {s, " "};
        s = {s, "#"};
        if ($urandom_range(0, 14) == 0) s[$urandom_range(1, s.len() - 1)] = junk[$urandom_range(0, junk.len() - 1)];
        return s;
    endfunction

    task automatic test_reset;
        string s = "12345678#";
        repeat (3) @(negedge clk);
        checks++;
        if (format_type !== 2'b00) begin
            errors++;
            $display("FAIL reset: format_type=%b expected 00", format_type);
        end
        reset = 1'b1;
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i]);
            checks++;
            if (format_type !== 2'b00) begin
                errors++;
                $display("FAIL reset_no_caret char %0d: format_type=%b expected 00", i, format_type);
            end
        end
    endtask

    task automatic test_reg_record;
        string recs[2] = '{"^242@000030f4: $31 <=12345678#", "^1234@000030f4: $1234<=12345678#"};
        logic [1:0] want[2] = '{2'b01, 2'b01};
        logic [1:0] e;
        string s;
        for (int r = 0; r < 2; r++) begin
            s = recs[r];
            for (int i = 0; i < s.len(); i++) begin
                send_char(s[i]);
                e = (i == s.len() - 1) ? want[r] : 2'b00;
                checks++;
                if (format_type !== e) begin
                    errors++;
                    $display("FAIL reg_record rec %0d char %0d: format_type=%b expected %b", r, i, format_type, e);
                end
            end
        end
    endtask

    task automatic test_mem_record;
        string recs[3] = '{"^338@00003130: *00000088 <= ffffb528#",
                           "^338@00003130: *00000088 <= Ffffb528#",
                           "^338@00003130: *00000088 <= ffffB528#"};
        logic [1:0] want[3] = '{2'b10, 2'b00, 2'b00};
        logic [1:0] e;
        string s;
        for (int r = 0; r < 3; r++) begin
            s = recs[r];
            for (int i = 0; i < s.len(); i++) begin
                send_char(s[i]);
                e = (i == s.len() - 1) ? want[r] : 2'b00;
                checks++;
                if (format_type !== e) begin
                    errors++;
                    $display("FAIL mem_record rec %0d char %0d: format_type=%b expected %b", r, i, format_type, e);
                end
            end
        end
    endtask

    task automatic test_data_len;
        string recs[5] = '{"^242@000030f4: $31 <=123215#",
                           "^242@000030f4: $31 <=1232158998#",
                           "^242@000030f4: $31 <=#",
                           "^338@00003130: *00000088 <= ffffb52812#",
                           "^338@00003130: *00000088 <= ffffb52B#"};
        string s;
        for (int r = 0; r < 5; r++) begin
            s = recs[r];
            for (int i = 0; i < s.len(); i++) begin
                send_char(s[i]);
                checks++;
                if (format_type !== 2'b00) begin
                    errors++;
                    $display("FAIL data_len rec %0d char %0d: format_type=%b expected 00", r, i, format_type);
                end
            end
        end
    endtask

    task automatic test_spaces;
        string recs[4] = '{"^242@000030f4: $31 <=   ab123215 #",
                           "^1@00000000:   $7   <=   abcdef01#",
                           "^9999@deadbeef:  *0000ffff   <=  01234567#",
                           "^5@0badf00d:*12345678<=9abcdef0#"};
        logic [1:0] want[4] = '{2'b00, 2'b01, 2'b10, 2'b10};
        logic [1:0] e;
        string s;
        for (int r = 0; r < 4; r++) begin
            s = recs[r];
            for (int i = 0; i < s.len(); i++) begin
                send_char(s[i]);
                e = (i == s.len() - 1) ? want[r] : 2'b00;
                checks++;
                if (format_type !== e) begin
                    errors++;
                    $display("FAIL spaces rec %0d char %0d: format_type=%b expected %b", r, i, format_type, e);
                end
            end
        end
    endtask

    task automatic test_field_limits;
        string recs[6] = '{"^12345@000030f4: $31 <=12345678#",
                           "^242@000030f4: $12345 <=12345678#",
                           "^242@000030f: $31 <=12345678#",
                           "^0@0123456789:$1<=12345678#",
                           "^7@000030f4:$0<=12345678#",
                           "^1234@000030f4: $1234<=12345678#"};
        logic [1:0] want[6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
        logic [1:0] e;
        string s;
        for (int r = 0; r < 6; r++) begin
            s = recs[r];
            for (int i = 0; i < s.len(); i++) begin
                send_char(s[i]);
                e = (i == s.len() - 1) ? want[r] : 2'b00;
                checks++;
                if (format_type !== e) begin
                    errors++;
                    $display("FAIL field_limits rec %0d char %0d: format_type=%b expected %b", r, i, format_type, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        string s = {"^1@00000001:$2<=00000003#", "^2@00000004:*00000005<=00000006#",
                    "^3@00000007:$8<=0000009#", "^4@0000000a:$11<=0000000b#"};
        logic [1:0] want[4] = '{2'b01, 2'b10, 2'b00, 2'b01};
        logic [1:0] e;
        int rec = 0;
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i]);
            e = (s[i] == "#") ? want[rec] : 2'b00;
            if (s[i] == "#") rec++;
            checks++;
            if (format_type !== e) begin
                errors++;
                $display("FAIL back_to_back char %0d: format_type=%b expected %b", i, format_type, e);
            end
        end
    endtask

    task automatic test_restart;
        string recs[2] = '{"^242@000030f4: $3^5@00000001:*00000002<=00000003#",
                           "^1@0000000^2@00000000:$1<=00000000#"};
        logic [1:0] want[2] = '{2'b10, 2'b01};
        logic [1:0] e;
        string s;
        for (int r = 0; r < 2; r++) begin
            s = recs[r];
            for (int i = 0; i < s.len(); i++) begin
                send_char(s[i]);
                e = (i == s.len() - 1) ? want[r] : 2'b00;
                checks++;
                if (format_type !== e) begin
                    errors++;
                    $display("FAIL restart rec %0d char %0d: format_type=%b expected %b", r, i, format_type, e);
                end
            end
        end
    endtask

    task automatic test_async_reset;
        string a = "^242@000030f4: $31 <=12345678#";
        string b = "^1@00000001: *0000";
        string c = "0002<=00000003#";
        for (int i = 0; i < a.len(); i++) send_char(a[i]);
        checks++;
        if (format_type !== 2'b01) begin
            errors++;
            $display("FAIL async_reset_pre: format_type=%b expected 01", format_type);
        end
        #2 reset = 1'b0;
        active = 1'b0;
        #1;
        checks++;
        if (format_type !== 2'b00) begin
            errors++;
            $display("FAIL async_reset_now: format_type=%b expected 00", format_type);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < b.len(); i++) send_char(b[i]);
        @(negedge clk);
        reset = 1'b0;
        active = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < c.len(); i++) begin
            send_char(c[i]);
            checks++;
            if (format_type !== 2'b00) begin
                errors++;
                $display("FAIL async_reset_tail char %0d: format_type=%b expected 00", i, format_type);
            end
        end
    endtask

    task automatic test_random;
        string s;
        for (int r = 0; r < 150; r++) begin
            s = rand_record();
            for (int i = 0; i < s.len(); i++) begin
                send_char(s[i]);
                checks++;
                if (format_type !== exp_ft) begin
                    errors++;
                    $display("FAIL random rec %0d char %0d in \"%s\": format_type=%b expected %b", r, i, s, format_type, exp_ft);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_reg_record();
        test_mem_record();
        test_data_len();
        test_spaces();
        test_field_limits();
        test_back_to_back();
        test_restart();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
